// File: rtl/crossbar_reg.sv
// Registered M-output by N-input lane crossbar. Routing is staged in a shadow map
// by put strobes and made live atomically by commit; out, source and pending are registered.
module crossbar_reg #(
  parameter int W = 3,
  parameter int N = 4,
  parameter int M = 4,
  parameter int D = 1,
  parameter logic [D-1:0] IDLE = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*D-1:0] in,
  output logic [M*D-1:0] out,
  input  logic [W-1:0]   from,
  input  logic [W-1:0]   to,
  input  logic           put,
  input  logic           commit,
  input  logic [W-1:0]   query,
  output logic [W-1:0]   source,
  output logic           pending
);

  localparam logic [W:0] N_L = (W+1)'(N);
  localparam logic [W:0] M_L = (W+1)'(M);

  logic [M-1:0] sh_v, act_v, sh_v_nxt, act_v_nxt;
  logic [W-1:0] sh_s [M];
  logic [W-1:0] act_s [M];
  logic [W-1:0] sh_s_nxt [M];
  logic [W-1:0] act_s_nxt [M];

  logic [M*D-1:0] out_nxt;
  logic [W-1:0]   source_nxt;
  logic           pending_nxt;
  logic           from_ok, to_ok, query_ok;

  // Indices are signed: a set sign bit is always out of range.
  assign from_ok  = !from[W-1]  && ({1'b0, from}  < N_L);
  assign to_ok    = !to[W-1]    && ({1'b0, to}    < M_L);
  assign query_ok = !query[W-1] && ({1'b0, query} < M_L);

  always_comb begin
    sh_v_nxt = sh_v;
    sh_s_nxt = sh_s;
    for (int k = 0; k < M; k++) begin
      if (put && to_ok && (to == W'(k))) begin
        sh_v_nxt[k] = from_ok;
        sh_s_nxt[k] = from_ok ? from : '0;
      end
    end

    // Commit sees the shadow with this cycle's put already applied.
    act_v_nxt = commit ? sh_v_nxt : act_v;
    act_s_nxt = commit ? sh_s_nxt : act_s;

    pending_nxt = 1'b0;
    for (int k = 0; k < M; k++) begin
      if ((sh_v_nxt[k] != act_v_nxt[k]) ||
          (sh_v_nxt[k] && (sh_s_nxt[k] != act_s_nxt[k])))
        pending_nxt = 1'b1;
    end
  end

  // Routing and readback use the active map as it stood before this edge.
  always_comb begin
    out_nxt = '0;
    for (int k = 0; k < M; k++) begin
      out_nxt[k*D +: D] = IDLE;
      for (int i = 0; i < N; i++) begin
        if (act_v[k] && (act_s[k] == W'(i)))
          out_nxt[k*D +: D] = in[i*D +: D];
      end
    end

    source_nxt = '1;
    for (int k = 0; k < M; k++) begin
      if (query_ok && (query == W'(k)) && act_v[k])
        source_nxt = act_s[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_v    <= '0;
      act_v   <= '0;
      for (int k = 0; k < M; k++) begin
        sh_s[k]  <= '0;
        act_s[k] <= '0;
      end
      out     <= {M{IDLE}};
      source  <= '1;
      pending <= 1'b0;
    end else begin
      sh_v    <= sh_v_nxt;
      act_v   <= act_v_nxt;
      sh_s    <= sh_s_nxt;
      act_s   <= act_s_nxt;
      out     <= out_nxt;
      source  <= source_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_crossbar_reg.sv
// Bench for crossbar_reg: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a map-level behavioural model.
module tb_crossbar_reg;
  localparam int W = 3, N = 4, M = 4, D = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in, out;
  logic [2:0]  from, to, query, source;
  logic        put, commit, pending;

  crossbar_reg #(.W(W), .N(N), .M(M), .D(D), .IDLE(8'h00)) dut (
    .clock(clock), .reset(reset), .in(in), .out(out),
    .from(from), .to(to), .put(put), .commit(commit),
    .query(query), .source(source), .pending(pending)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;

  // Model: shadow/active maps as plain integer arrays.
  int          sh_v [4], sh_s [4], ac_v [4], ac_s [4];
  logic [31:0] e_out;
  logic [2:0]  e_src;
  logic        e_pend;
  bit          model_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    int f, t, q;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        sh_v[k] = 0; sh_s[k] = 0; ac_v[k] = 0; ac_s[k] = 0;
      end
      e_out = 32'h0; e_src = 3'b111; e_pend = 1'b0;
      model_ok = 1;
    end else begin
      for (int k = 0; k < 4; k++)
        e_out[8*k +: 8] = (ac_v[k] != 0) ? 8'(in >> (8 * ac_s[k])) : 8'h00;
      q = $signed(query);
      e_src = (q >= 0 && q < M && ac_v[q] != 0) ? 3'(ac_s[q]) : 3'b111;
      f = $signed(from);
      t = $signed(to);
      if (put && t >= 0 && t < M) begin
        sh_v[t] = (f >= 0 && f < N) ? 1 : 0;
        sh_s[t] = (sh_v[t] != 0) ? f : 0;
      end
      if (commit) begin
        ac_v = sh_v;
        ac_s = sh_s;
      end
      e_pend = 1'b0;
      for (int k = 0; k < 4; k++)
        if (sh_v[k] != ac_v[k] || (sh_v[k] != 0 && sh_s[k] != ac_s[k])) e_pend = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      chk("model out", out, e_out);
      chk("model source", 32'(source), 32'(e_src));
      chk("model pending", 32'(pending), 32'(e_pend));
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; in = 32'h44332211; put = 1'b0; commit = 1'b0;
    from = 3'd0; to = 3'd0; query = 3'd0;
    step(); step();
    chk("rst out", out, 32'h00000000);
    chk("rst source", 32'(source), 32'd7);
    chk("rst pending", 32'(pending), 32'd0);
    reset = 1'b0;

    // put 2->3, commit two cycles later
    put = 1'b1; from = 3'd2; to = 3'd3;
    step();
    chk("p39 pend after put", 32'(pending), 32'd1);
    chk("p39 lane3 pre", 32'(out[31:24]), 32'h00);
    put = 1'b0;
    step();
    chk("p39 pend hold", 32'(pending), 32'd1);
    commit = 1'b1;
    step();
    chk("p39 pend after commit", 32'(pending), 32'd0);
    chk("p39 lane3 commit edge", 32'(out[31:24]), 32'h00);
    commit = 1'b0;
    step();
    chk("p39 lane3 routed", 32'(out[31:24]), 32'h33);

    // put 1->0 with commit in the same cycle
    put = 1'b1; commit = 1'b1; from = 3'd1; to = 3'd0; query = 3'd0;
    step();
    chk("p40 pend", 32'(pending), 32'd0);
    put = 1'b0; commit = 1'b0;
    step();
    chk("p40 lane0", 32'(out[7:0]), 32'h22);
    chk("p40 source", 32'(source), 32'd1);

    // fan-out of input 3
    put = 1'b1; from = 3'd3; to = 3'd0; step();
    to = 3'd1; step();
    to = 3'd2; step();
    put = 1'b0; commit = 1'b1; step();
    commit = 1'b0; step();
    chk("p41 fanout", 32'(out[23:0]), 32'h444444);
    in[31:24] = 8'h55;
    step();
    chk("p41 fanout latency", 32'(out[23:0]), 32'h555555);

    // disconnects via negative and too-large source
    put = 1'b1; from = 3'b111; to = 3'd0; step();
    from = 3'd6; to = 3'd1; step();
    put = 1'b0; commit = 1'b1; query = 3'd1; step();
    commit = 1'b0; step();
    chk("p42 lanes01", 32'(out[15:0]), 32'h0000);
    chk("p42 source", 32'(source), 32'd7);
    put = 1'b1; from = 3'd2; to = 3'd5; step();
    put = 1'b0;
    chk("p42 bad to pend", 32'(pending), 32'd0);
    step();
    chk("p42 bad to lane2", 32'(out[23:16]), 32'h55);

    // uncommitted change discarded by reset
    put = 1'b1; commit = 1'b1; from = 3'b111; to = 3'd3; step();
    from = 3'd2; commit = 1'b0; step();
    put = 1'b0;
    chk("p43 pend before rst", 32'(pending), 32'd1);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("p43 pend", 32'(pending), 32'd0);
    chk("p43 lane3", 32'(out[31:24]), 32'h00);
    commit = 1'b1; step();
    commit = 1'b0; step();
    chk("p43 lane3 after commit", 32'(out[31:24]), 32'h00);

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      in     = $urandom;
      from   = 3'($urandom_range(0, 7));
      to     = 3'($urandom_range(0, 7));
      query  = 3'($urandom_range(0, 7));
      put    = ($urandom_range(0, 1) == 0);
      commit = ($urandom_range(0, 3) == 0);
      reset  = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0; put = 1'b0; commit = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
